latch_event_arbiter: RTL



---
 rtl/latch_event_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/latch_event_arbiter.sv
// latch_event_arbiter: services a bank of N negedge event latches one event at
// a time. It owns the latch enable/clear lines, gathers latched edges into a
// pending vector and presents them round-robin over a valid/ack handshake.
// After each ack it clears the serviced latch and waits for it to settle.
// Optional build macro: LATCH_ACK_TIMEOUT_EN adds an ack timeout that forces
// the service to proceed and records the channel in timeout_err / lost.
module latch_event_arbiter #(
    parameter int N          = 4,
    parameter int IDW        = 2,
    parameter int CLR_CYCLES = 2,
    parameter int SETTLE_MAX = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   en_mask,
    output logic [N-1:0]   latch_enable,
    output logic [N-1:0]   latch_clear,
    input  logic [N-1:0]   latch_sync,
    input  logic [N-1:0]   latch_edge,
    output logic [N-1:0]   pending,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ack,
    output logic           busy,
    output logic           settle_err,
`ifdef LATCH_ACK_TIMEOUT_EN
    output logic           timeout_err,
    output logic [N-1:0]   lost,
`endif
    input  logic           err_clr
);

    // Reject parameter sets that cannot address every channel.
    if ((2 ** IDW) < N || N < 1 || CLR_CYCLES < 1 || SETTLE_MAX < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("latch_event_arbiter: illegal parameter combination");
    end

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int SW = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, CLEAR, SETTLE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic           evt_valid_q, evt_valid_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   latch_enable_q, latch_enable_d;
    logic [N-1:0]   latch_clear_q, latch_clear_d;
    logic [CW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
    logic           settle_err_q, settle_err_d;

    logic           found;
    logic [IDW-1:0] cand;
    logic           ack_take;
    logic           settle_set;
    logic [N-1:0]   pend_clr;
    logic [N-1:0]   clr_sel;

`ifdef LATCH_ACK_TIMEOUT_EN
    logic [15:0]    to_cnt_q, to_cnt_d;
    logic           timeout_err_q, timeout_err_d;
    logic [N-1:0]   lost_q, lost_d;
    logic           to_fire;
    logic [N-1:0]   lost_set;
`endif

    // Next-state logic: arbitration, handshake, clear sequencing and settle wait.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        evt_id_d     = evt_id_q;
        evt_valid_d  = evt_valid_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;
        settle_set   = 1'b0;
        pend_clr     = '0;
        clr_sel      = '0;
        found        = 1'b0;
        cand         = '0;
        ack_take     = evt_valid_q & evt_ack;
`ifdef LATCH_ACK_TIMEOUT_EN
        to_fire  = (state_q == PRESENT) & ~ack_take & en_mask[evt_id_q]
                   & (to_cnt_q == 16'(TIMEOUT - 1));
        lost_set = '0;
        to_cnt_d = (state_q == PRESENT) ? to_cnt_q + 16'd1 : 16'd0;
`endif

        case (state_q)
            IDLE: begin
                evt_valid_d = 1'b0;
                // Round-robin: search upward from ptr+1 with wrap-around.
                for (int k = 1; k <= N; k++) begin
                    cand = IDW'((int'(ptr_q) + k) % N);
                    if (!found && pending_q[cand]) begin
                        found    = 1'b1;
                        evt_id_d = cand;
                    end
                end
                if (found) begin
                    ptr_d   = evt_id_d;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                evt_valid_d = 1'b1;
                if (!en_mask[evt_id_q]) begin
                    // Masking already clears the latch; skip straight to settle.
                    evt_valid_d  = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else if (ack_take
`ifdef LATCH_ACK_TIMEOUT_EN
                             || to_fire
`endif
                            ) begin
                    evt_valid_d        = 1'b0;
                    pend_clr[evt_id_q] = 1'b1;
                    clr_cnt_d          = '0;
                    state_d            = CLEAR;
`ifdef LATCH_ACK_TIMEOUT_EN
                    lost_set[evt_id_q] = to_fire;
`endif
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (!latch_sync[evt_id_q] || latch_edge[evt_id_q]) begin
                    state_d = IDLE;
                end else if (settle_cnt_q == SW'(SETTLE_MAX - 1)) begin
                    settle_set = 1'b1;
                    state_d    = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear is asserted in step with the CLEAR state, and always while masked.
        if (state_d == CLEAR) clr_sel[evt_id_d] = 1'b1;
        latch_clear_d  = ~en_mask | clr_sel;
        latch_enable_d = en_mask;
        // A new edge beats the service clear; a masked channel never pends.
        pending_d      = ((pending_q & ~pend_clr) | (latch_edge & en_mask)) & en_mask;
        settle_err_d   = settle_set | (settle_err_q & ~err_clr);
`ifdef LATCH_ACK_TIMEOUT_EN
        timeout_err_d  = to_fire | (timeout_err_q & ~err_clr);
        lost_d         = lost_set | (lost_q & ~{N{err_clr}});
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= IDW'(N - 1);
            evt_id_q       <= '0;
            evt_valid_q    <= 1'b0;
            pending_q      <= '0;
            latch_enable_q <= '0;
            latch_clear_q  <= '1;
            clr_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            settle_err_q   <= 1'b0;
`ifdef LATCH_ACK_TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
            lost_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            evt_id_q       <= evt_id_d;
            evt_valid_q    <= evt_valid_d;
            pending_q      <= pending_d;
            latch_enable_q <= latch_enable_d;
            latch_clear_q  <= latch_clear_d;
            clr_cnt_q      <= clr_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            settle_err_q   <= settle_err_d;
`ifdef LATCH_ACK_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            timeout_err_q  <= timeout_err_d;
            lost_q         <= lost_d;
`endif
        end
    end

    assign latch_enable = latch_enable_q;
    assign latch_clear  = latch_clear_q;
    assign pending      = pending_q;
    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign busy         = (state_q != IDLE);
    assign settle_err   = settle_err_q;
`ifdef LATCH_ACK_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
    assign lost         = lost_q;
`endif

endmodule
